btb_predictor_param: RTL and testbench

Parametrised branch predictor for the fetch stage of the 5-stage RV32I pipeline. It combines a direct-mapped BTB (valid, tag, target and jump flag per entry) with a separate pattern history table of saturating counters.
- Fetch does a combinational lookup.
- Execute resolves the branch, updates both tables, and produces the mispredict flag and redirect PC.
- Two saturating performance counters track resolved control-flow instructions and mispredicts.

---
 rtl/bp_pkg.sv | 42 ++++
 rtl/btb_predictor_param_if.sv | 41 ++++
 rtl/bp_pht.sv | 63 ++++++
 rtl/btb_predictor_param.sv | 108 ++++++++++
 tb/tb_btb_predictor_param.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
//   btb_entry_t : one BTB line {valid, tag, target, is_jump}. The tag field is
//                 sized for the smallest legal BTB. Narrower tags are stored
//                 zero-extended.
//   ctr_rst     : reset value of a CTR_BITS-wide counter (weakly not-taken).
//   ctr_next    : saturating increment/decrement of a counter.
// Counters are handled in a CTR_MAX_W-wide container, so CTR_BITS <= CTR_MAX_W.
package bp_pkg;

  localparam int ADDR_W    = 32;
  localparam int CTR_MAX_W = 8;

  // Index widths for the default geometry. Modules re-derive them from
  // their own parameters.
  localparam int BTB_IDX_W_DEF = $clog2(16);
  localparam int PHT_IDX_W_DEF = $clog2(64);

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic        is_jump;
  } btb_entry_t;

  function automatic logic [CTR_MAX_W-1:0] ctr_max(input int bits);
    return {CTR_MAX_W{1'b1}} >> (CTR_MAX_W - bits);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_rst(input int bits);
    return ctr_max(bits) >> 1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic taken,
                                                    input int bits);
    if (taken)
      return (ctr == ctr_max(bits)) ? ctr : ctr + 1'b1;
    else
      return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/btb_predictor_param_if.sv
// Fetch/execute bundle between the pipeline and the branch predictor.
//   fetch   : i_pc_f -> o_hit_f, o_pred_taken_f, o_pred_target_f
//   execute : i_valid_e, i_pc_e, i_is_branch_e, i_is_jump_e, i_taken_e,
//             i_target_e, i_pred_taken_e, i_pred_target_e
//             -> o_mispredict_e, o_redirect_pc_e
//   perf    : o_branch_cnt, o_mispred_cnt
// master = pipeline side, slave = predictor side.
interface btb_predictor_param_if #(
  parameter int PERF_BITS = 16
);
  logic [31:0]          i_pc_f;
  logic                 o_hit_f;
  logic                 o_pred_taken_f;
  logic [31:0]          o_pred_target_f;
  logic                 i_valid_e;
  logic [31:0]          i_pc_e;
  logic                 i_is_branch_e;
  logic                 i_is_jump_e;
  logic                 i_taken_e;
  logic [31:0]          i_target_e;
  logic                 i_pred_taken_e;
  logic [31:0]          i_pred_target_e;
  logic                 o_mispredict_e;
  logic [31:0]          o_redirect_pc_e;
  logic [PERF_BITS-1:0] o_branch_cnt;
  logic [PERF_BITS-1:0] o_mispred_cnt;

  modport master (
    output i_pc_f, i_valid_e, i_pc_e, i_is_branch_e, i_is_jump_e, i_taken_e,
           i_target_e, i_pred_taken_e, i_pred_target_e,
    input  o_hit_f, o_pred_taken_f, o_pred_target_f, o_mispredict_e,
           o_redirect_pc_e, o_branch_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_pc_f, i_valid_e, i_pc_e, i_is_branch_e, i_is_jump_e, i_taken_e,
           i_target_e, i_pred_taken_e, i_pred_target_e,
    output o_hit_f, o_pred_taken_f, o_pred_target_f, o_mispredict_e,
           o_redirect_pc_e, o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table of saturating counters.
//   i_idx_f      : fetch PC index bits pc[PB+1:2]
//   o_ctr_msb_f  : MSB of the addressed counter (async read)
//   i_upd_e      : update strobe for a resolved conditional branch
//   i_idx_e      : execute PC index bits
//   i_taken_e    : resolved outcome
// Optional macro BP_GSHARE_EN: both indices are XORed with a non-speculative
// global history register that shifts in each resolved branch outcome.
module bp_pht
  import bp_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 6,
  localparam int PB         = $clog2(PHT_ENTRIES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [PB-1:0] i_idx_f,
  output logic          o_ctr_msb_f,
  input  logic          i_upd_e,
  input  logic [PB-1:0] i_idx_e,
  input  logic          i_taken_e
);

  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_rst(CTR_BITS));

  logic [CTR_BITS-1:0] ctr [PHT_ENTRIES];
  logic [PB-1:0]       rd_idx;
  logic [PB-1:0]       wr_idx;
  logic [CTR_BITS-1:0] ctr_nxt;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      ghr <= '0;
    else if (i_upd_e)
      ghr <= GHR_BITS'({ghr, i_taken_e});
  end

  assign rd_idx = i_idx_f ^ PB'(ghr);
  assign wr_idx = i_idx_e ^ PB'(ghr);
`else
  localparam int GHR_BITS_UNUSED = GHR_BITS;
  assign rd_idx = i_idx_f;
  assign wr_idx = i_idx_e;
`endif

  assign o_ctr_msb_f = ctr[rd_idx][CTR_BITS-1];
  assign ctr_nxt     = CTR_BITS'(ctr_next(CTR_MAX_W'(ctr[wr_idx]), i_taken_e, CTR_BITS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        ctr[i] <= CTR_RST;
    end else if (i_upd_e) begin
      ctr[wr_idx] <= ctr_nxt;
    end
  end

endmodule

// File: rtl/btb_predictor_param.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a PHT of saturating
// counters (bp_pht). Fetch lookup is combinational. Execute resolution
// produces the mispredict/redirect and updates both tables at the clock edge.
// A lookup in the same cycle as an update sees the old contents.
// Ports: i_clk, i_rst (async, active-high), bus (btb_predictor_param_if.slave).
// Optional macro BP_GSHARE_EN: gshare indexing inside bp_pht.
// The PERF_BITS value must match the one given to the interface instance.
module btb_predictor_param
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 6,
  parameter int PERF_BITS   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  btb_predictor_param_if.slave  bus
);

  localparam int IB = $clog2(BTB_ENTRIES);
  localparam int PB = $clog2(PHT_ENTRIES);

  btb_entry_t           btb [BTB_ENTRIES];
  btb_entry_t           ent_f;
  logic [IB-1:0]        idx_f;
  logic [IB-1:0]        idx_e;
  logic [29:0]          tag_f;
  logic [29:0]          tag_e;
  logic                 hit_f;
  logic                 ctr_msb_f;
  logic                 pred_f;
  logic                 res_e;
  logic                 mis_e;
  logic                 pht_upd_e;
  logic [PERF_BITS-1:0] branch_cnt;
  logic [PERF_BITS-1:0] mispred_cnt;
  logic [1:0]           unused_pc_lsb;

  assign unused_pc_lsb = bus.i_pc_f[1:0];

  // Fetch lookup
  assign idx_f = bus.i_pc_f[IB+1:2];
  assign tag_f = 30'(bus.i_pc_f[31:IB+2]);
  assign ent_f = btb[idx_f];
  assign hit_f  = ent_f.valid && (ent_f.tag == tag_f);
  assign pred_f = hit_f && (ent_f.is_jump || ctr_msb_f);

  assign bus.o_hit_f         = !i_rst && hit_f;
  assign bus.o_pred_taken_f  = !i_rst && pred_f;
  assign bus.o_pred_target_f = (!i_rst && pred_f) ? ent_f.target : 32'd0;

  // Execute resolution
  assign idx_e = bus.i_pc_e[IB+1:2];
  assign tag_e = 30'(bus.i_pc_e[31:IB+2]);
  assign res_e = bus.i_valid_e && (bus.i_is_branch_e || bus.i_is_jump_e);
  assign mis_e = res_e && ((bus.i_pred_taken_e != bus.i_taken_e) ||
                           (bus.i_taken_e && (bus.i_pred_target_e != bus.i_target_e)));
  // Both flags high is treated as a jump, so such an op leaves the PHT alone.
  assign pht_upd_e = res_e && bus.i_is_branch_e && !bus.i_is_jump_e;

  assign bus.o_mispredict_e  = !i_rst && mis_e;
  assign bus.o_redirect_pc_e = (!i_rst && res_e) ?
                               (bus.i_taken_e ? bus.i_target_e : bus.i_pc_e + 32'd4) : 32'd0;

  bp_pht #(
    .PHT_ENTRIES (PHT_ENTRIES),
    .CTR_BITS    (CTR_BITS),
    .GHR_BITS    (GHR_BITS)
  ) u_pht (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_idx_f     (bus.i_pc_f[PB+1:2]),
    .o_ctr_msb_f (ctr_msb_f),
    .i_upd_e     (pht_upd_e),
    .i_idx_e     (bus.i_pc_e[PB+1:2]),
    .i_taken_e   (bus.i_taken_e)
  );

  // BTB update: allocate/overwrite only on taken, never on not-taken
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        btb[i] <= '0;
    end else if (res_e && bus.i_taken_e) begin
      btb[idx_e] <= '{valid: 1'b1, tag: tag_e, target: bus.i_target_e,
                      is_jump: bus.i_is_jump_e};
    end
  end

  // Performance counters, saturating at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_e && !(&branch_cnt))
        branch_cnt <= branch_cnt + 1'b1;
      if (mis_e && !(&mispred_cnt))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign bus.o_branch_cnt  = branch_cnt;
  assign bus.o_mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_btb_predictor_param.sv
// Directed bench for btb_predictor_param with a scoreboard queue: each drive
// step pushes its expected outputs, and check_all pops and compares them
// mid-cycle. Inputs change on the falling edge. Compares run 2-3 ns later,
// well before the rising edge.
module tb_btb_predictor_param;

  typedef enum int {K_HIT, K_PRED, K_TGT, K_MP, K_RDR, K_BCNT, K_MCNT} kind_t;
  typedef struct {
    kind_t       kind;
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_predictor_param_if #(.PERF_BITS(16)) bus ();

  btb_predictor_param #(
    .BTB_ENTRIES (16),
    .PHT_ENTRIES (64),
    .CTR_BITS    (2),
    .GHR_BITS    (6),
    .PERF_BITS   (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  sb_t sbq[$];
  int  n_cmp  = 0;
  int  n_bad  = 0;
  int  exp_br = 0;
  int  exp_mp = 0;

  task automatic push(input kind_t k, input string t, input logic [31:0] e);
    sb_t s;
    s.kind = k; s.tag = t; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic check_all();
    sb_t         s;
    logic [31:0] obs;
    #2;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      case (s.kind)
        K_HIT:   obs = 32'(bus.o_hit_f);
        K_PRED:  obs = 32'(bus.o_pred_taken_f);
        K_TGT:   obs = bus.o_pred_target_f;
        K_MP:    obs = 32'(bus.o_mispredict_e);
        K_RDR:   obs = bus.o_redirect_pc_e;
        K_BCNT:  obs = 32'(bus.o_branch_cnt);
        default: obs = 32'(bus.o_mispred_cnt);
      endcase
      n_cmp++;
      assert (obs === s.exp) else begin
        n_bad++;
        $error("FAIL %s.%s observed=%0h expected=%0h", s.tag, s.kind.name(), obs, s.exp);
      end
    end
  endtask

  task automatic idle_e();
    bus.i_valid_e = 1'b0; bus.i_pc_e = '0; bus.i_is_branch_e = 1'b0;
    bus.i_is_jump_e = 1'b0; bus.i_taken_e = 1'b0; bus.i_target_e = '0;
    bus.i_pred_taken_e = 1'b0; bus.i_pred_target_e = '0;
  endtask

  task automatic set_e(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptg);
    bus.i_valid_e = v; bus.i_pc_e = pc; bus.i_is_branch_e = br; bus.i_is_jump_e = jmp;
    bus.i_taken_e = tk; bus.i_target_e = tgt; bus.i_pred_taken_e = pt; bus.i_pred_target_e = ptg;
  endtask

  task automatic exp_fetch(input string t, input logic [31:0] pc, input logic hit,
                           input logic pred, input logic [31:0] tgt);
    bus.i_pc_f = pc;
    push(K_HIT, t, 32'(hit));
    push(K_PRED, t, 32'(pred));
    push(K_TGT, t, tgt);
  endtask

  // Drive one execute op and its expected flush outputs. The counter model
  // advances here and is observed from the following cycle on.
  task automatic exp_res(input string t, input logic v, input logic [31:0] pc, input logic br,
                         input logic jmp, input logic tk, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg,
                         input logic mp, input logic [31:0] rdr);
    set_e(v, pc, br, jmp, tk, tgt, pt, ptg);
    push(K_MP, t, 32'(mp));
    push(K_RDR, t, rdr);
    if (v && (br || jmp)) begin
      if (exp_br < 32'hFFFF) exp_br++;
      if (mp && exp_mp < 32'hFFFF) exp_mp++;
    end
  endtask

  task automatic exp_cnt(input string t);
    push(K_BCNT, t, 32'(exp_br));
    push(K_MCNT, t, 32'(exp_mp));
  endtask

  task automatic tick();
    check_all();
    @(negedge clk);
    idle_e();
  endtask

  initial begin : stim
    logic        pt;
    logic [31:0] ptg;
    logic        tk;
    logic        mp;
    int          win_mp;
    int          exp_win;

    rst = 1'b1;
    bus.i_pc_f = 32'h100;
    idle_e();

    // 1. Reset: outputs forced low even with a live resolve on the bus
    @(negedge clk);
    set_e(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    exp_fetch("rst_f", 32'h100, 1'b0, 1'b0, 32'h0);
    push(K_MP, "rst_e", 32'h0);
    push(K_RDR, "rst_e", 32'h0);
    exp_cnt("rst_cnt");
    check_all();
    idle_e();
    @(negedge clk);
    rst = 1'b0;
    exp_fetch("t1_f", 32'h100, 1'b0, 1'b0, 32'h0);
    exp_cnt("t1_cnt");
    tick();

`ifndef BP_GSHARE_EN
    // 2. First taken branch allocates; same-cycle lookup still misses
    exp_fetch("t2_pre", 32'h100, 1'b0, 1'b0, 32'h0);
    exp_res("t2_res", 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1'b1, 32'h80);
    tick();
    exp_cnt("t2_cnt");
    exp_fetch("t2_post", 32'h100, 1'b1, 1'b1, 32'h80);
    tick();

    // 3. Same BTB index, different tag
    exp_fetch("t3_alias", 32'h140, 1'b0, 1'b0, 32'h0);
    tick();

    // 4. Counter saturation and decrement
    for (int i = 0; i < 4; i++) begin
      exp_res("t4_tk", 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 1'b0, 32'h80);
      tick();
    end
    exp_res("t4_nt1", 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
    tick();
    exp_fetch("t4_after_nt1", 32'h100, 1'b1, 1'b1, 32'h80);
    exp_res("t4_nt2", 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
    tick();
    exp_fetch("t4_after_nt2", 32'h100, 1'b1, 1'b0, 32'h0);
    // direction right, target wrong
    exp_res("t4_tgt", 1, 32'h100, 1, 0, 1, 32'h90, 1, 32'h80, 1'b1, 32'h90);
    tick();
    exp_fetch("t4_newtgt", 32'h100, 1'b1, 1'b1, 32'h90);
    // bubble carrying a taken branch must change nothing
    exp_res("t4_bubble", 0, 32'h100, 1, 0, 1, 32'hA0, 0, 32'h0, 1'b0, 32'h0);
    tick();
    exp_fetch("t4_post_bub", 32'h100, 1'b1, 1'b1, 32'h90);
    exp_cnt("t4_cnt");
    tick();

    // 5. Jump at 0x200 evicts 0x100 (same index); lookup during update misses
    exp_fetch("t5_same_cyc", 32'h200, 1'b0, 1'b0, 32'h0);
    exp_res("t5_jal", 1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h0, 1'b1, 32'h400);
    tick();
    exp_fetch("t5_jump_hit", 32'h200, 1'b1, 1'b1, 32'h400);
    tick();
    exp_fetch("t5_evicted", 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    // PHT[0] left at 2 by the jump: two not-taken reach 0, one taken gives 1
    exp_res("t5_nt_a", 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h0, 1'b0, 32'h104);
    tick();
    exp_res("t5_nt_b", 1, 32'h100, 1, 0, 0, 32'h80, 0, 32'h0, 1'b0, 32'h104);
    tick();
    exp_res("t5_tk", 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1'b1, 32'h80);
    tick();
    exp_fetch("t5_pht_chk", 32'h100, 1'b1, 1'b0, 32'h0);
    exp_cnt("t5_cnt");
    tick();
`endif

    // 6. Alternating branch at 0x300 from a clean state
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    exp_cnt("t6_rst_cnt");
    tick();
`ifdef BP_GSHARE_EN
    exp_win = 0;
`else
    exp_win = 8;
`endif
    win_mp = 0;
    for (int r = 1; r <= 20; r++) begin
      tk = r[0];
      bus.i_pc_f = 32'h300;
      #1;
      pt  = bus.o_pred_taken_f;
      ptg = bus.o_pred_target_f;
`ifdef BP_GSHARE_EN
      mp = tk && (r <= 7);
`else
      mp = 1'b1;
`endif
      exp_res($sformatf("t6_r%0d", r), 1, 32'h300, 1, 0, tk, 32'h380, pt, ptg, mp,
              tk ? 32'h380 : 32'h304);
      check_all();
      if (r >= 13 && bus.o_mispredict_e) win_mp++;
      @(negedge clk);
      idle_e();
    end
    n_cmp++;
    assert (win_mp === exp_win) else begin
      n_bad++;
      $error("FAIL t6_window observed=%0d expected=%0d", win_mp, exp_win);
    end
    exp_cnt("t6_cnt");
    tick();

    // 7. Branch counter saturation with jumps at 0x500 (index 0 holds 0x300)
    bus.i_pc_f = 32'h500;
    exp_fetch("t7_miss", 32'h500, 1'b0, 1'b0, 32'h0);
    exp_res("t7_first", 1, 32'h500, 0, 1, 1, 32'h600, 0, 32'h0, 1'b1, 32'h600);
    tick();
    for (int i = 0; i < 65538; i++) begin
      exp_res("t7_jmp", 1, 32'h500, 0, 1, 1, 32'h600, 1, 32'h600, 1'b0, 32'h600);
      tick();
    end
    exp_cnt("t7_sat");
    exp_fetch("t7_hit", 32'h500, 1'b1, 1'b1, 32'h600);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
